seq_pattern_tx: RTL and testbench

Serial frame transmitter that generates the bit stream consumed by the 1011 sequence detector. It accepts a parallel data word over a valid/ready handshake, then emits one bit at a time: the sync preamble 1011 first, then the data word MSB first, and optionally an even-parity bit. Bit advance is paced by an external bit-enable tick. It sits upstream of the detector, either on the same serial link or in loopback test harnesses.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_tx_shifter.sv | 30 +++
 rtl/seq_pattern_tx.sv | 170 +++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 sync transmitter and detector pair.
// The PARITY state only exists when SEQ_TX_PARITY_EN is defined.
package seq_pkg;

  localparam int         SYNC_W_DEF        = 4;
  localparam logic [3:0] SYNC_PATTERN_1011 = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
`ifdef SEQ_TX_PARITY_EN
    , PARITY = 2'd3
`endif
  } tx_state_t;

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable left-shift register exposing its MSB and the bit that becomes
// the MSB after the next shift.
module seq_tx_shifter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadData,
  input  logic             i_shift,
  output logic             o_msb,
  output logic             o_nextMsb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_loadData;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb     = r_data[WIDTH-1];
  assign o_nextMsb = r_data[WIDTH-2];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: 1011 preamble, then the payload MSB first, paced by bit_en.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_1011,
  parameter logic              IDLE_LEVEL   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_sync,
  output logic              busy,
  output logic              frame_done
);

  localparam int SHIFT_W = SYNC_W + DATA_W;
`ifdef SEQ_TX_PARITY_EN
  localparam int FRAME_L = SHIFT_W + 1;
`else
  localparam int FRAME_L = SHIFT_W;
`endif
  localparam int CNT_W = $clog2(FRAME_L + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(SHIFT_W - 1);

  tx_state_t        r_state;
  tx_state_t        w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             r_outBit;
  logic             r_outValid;
  logic             r_outSync;
  logic             r_frameDone;
  logic             w_nextBit;
  logic             w_nextDone;
  logic             w_load;
  logic             w_shift;
  logic             w_shiftMsb;
  logic             w_shiftNextMsb;
  logic             r_parity;

  seq_tx_shifter #(
    .WIDTH (SHIFT_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_loadData ({SYNC_PATTERN, in_data}),
    .i_shift    (w_shift),
    .o_msb      (w_shiftMsb),
    .o_nextMsb  (w_shiftNextMsb)
  );

  // Next state plus the value each output flop takes, so every output is registered.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextDone  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_nextBit   = IDLE_LEVEL;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_nextState = SYNC;
          w_nextCnt   = '0;
        end
      end
      SYNC: begin
        if (bit_en) begin
          w_shift   = 1'b1;
          w_nextCnt = r_cnt + CNT_W'(1);
          if (r_cnt == SYNC_LAST) begin
            w_nextState = DATA;
          end
        end
      end
      DATA: begin
        if (bit_en) begin
          w_shift   = 1'b1;
          w_nextCnt = r_cnt + CNT_W'(1);
          if (r_cnt == DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
            w_nextState = PARITY;
`else
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
`endif
          end
        end
      end
`ifdef SEQ_TX_PARITY_EN
      PARITY: begin
        if (bit_en) begin
          w_nextState = IDLE;
          w_nextDone  = 1'b1;
          w_nextCnt   = r_cnt + CNT_W'(1);
        end
      end
`endif
      default: w_nextState = IDLE;
    endcase

    // The shifter updates on the same edge, so look one bit ahead of its MSB.
    case (w_nextState)
      SYNC, DATA: begin
        if (w_load) begin
          w_nextBit = SYNC_PATTERN[SYNC_W-1];
        end else if (w_shift) begin
          w_nextBit = w_shiftNextMsb;
        end else begin
          w_nextBit = w_shiftMsb;
        end
      end
`ifdef SEQ_TX_PARITY_EN
      PARITY: w_nextBit = r_parity;
`endif
      default: w_nextBit = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_outBit    <= IDLE_LEVEL;
      r_outValid  <= 1'b0;
      r_outSync   <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_outBit    <= w_nextBit;
      r_outValid  <= (w_nextState != IDLE);
      r_outSync   <= (w_nextState == SYNC);
      r_frameDone <= w_nextDone;
    end
  end

`ifdef SEQ_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^in_data;
    end
  end
`else
  assign r_parity = 1'b0;
`endif

  assign in_ready   = (r_state == IDLE) && !reset;
  assign busy       = (r_state != IDLE);
  assign out_bit    = r_outBit;
  assign out_valid  = r_outValid;
  assign out_sync   = r_outSync;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues expected bits, a
// negedge monitor pops and compares them on every bit_en advance.
module tb_seq_pattern_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int FRAME_L = 13;
  localparam bit PAR_EN  = 1'b1;
`else
  localparam int FRAME_L = 12;
  localparam bit PAR_EN  = 1'b0;
`endif

  typedef struct {
    logic b;
    logic s;
    int   hold;
    logic last;
    int   idx;
  } expBit_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_sync;
  logic       busy;
  logic       frame_done;

  expBit_t expQ[$];
  int      vectors = 0;
  int      fails   = 0;
  int      enPeriod = 1;
  int      phase    = 0;
  bit      monEn    = 1'b0;
  bit      pendingDone = 1'b0;
  bit      loopMode = 1'b0;
  int      holdCnt  = 0;
  int      detCnt   = 0;
  logic [3:0] detReg = 4'b0000;

  seq_pattern_tx dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_sync   (out_sync),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    phase++;
    bit_en = (enPeriod <= 1) ? 1'b1 : ((phase % enPeriod) == 0);
  endtask

  task automatic pushFrame(input logic [11:0] expBits, input logic expPar, input int hold, input int nBits);
    expBit_t e;
    for (int i = 0; i < nBits; i++) begin
      if (i < 12) begin
        e.b = expBits[11-i];
        e.s = (i < 4);
      end else begin
        e.b = expPar;
        e.s = 1'b0;
      end
      e.hold = hold;
      e.last = (i == FRAME_L - 1);
      e.idx  = i;
      expQ.push_back(e);
    end
  endtask

  // Wait for ready, present the word, and return in the first bit's cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic [11:0] expBits, input logic expPar,
                               input int period, input int nBits);
    int guard;
    guard = 0;
    while (!in_ready && guard < 500) begin
      tick();
      guard++;
    end
    checkOutput("ready_wait", in_ready, 1);
    enPeriod = period;
    in_data  = data;
    in_valid = 1'b1;
    pushFrame(expBits, expPar, period, nBits);
    tick();
    phase    = 1;
    bit_en   = (period <= 1);
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int guard;
    guard = 0;
    while (!frame_done && guard < 500) begin
      tick();
      guard++;
    end
    checkOutput("done_wait", frame_done, 1);
  endtask

  // Monitor: compare every advanced bit, its hold length, and the frame_done pulse.
  always @(negedge clk) begin
    expBit_t e;
    if (monEn) begin
      checkOutput("frame_done", frame_done, pendingDone);
      if (pendingDone) begin
        checkOutput("done_ready", in_ready, 1);
        checkOutput("done_idle", out_valid, 0);
      end
      pendingDone = 1'b0;
      if (out_valid) begin
        holdCnt++;
        if (bit_en) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_bit", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("bit%0d", e.idx), out_bit, e.b);
            checkOutput($sformatf("sync%0d", e.idx), out_sync, e.s);
            checkOutput($sformatf("hold%0d", e.idx), holdCnt, e.hold);
            pendingDone = e.last;
            detReg = {detReg[2:0], out_bit};
            if (loopMode && detReg == 4'b1011) begin
              detCnt++;
              checkOutput("det_position", e.idx, 3);
            end
          end
          holdCnt = 0;
        end
      end else begin
        holdCnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int guard;
    int detBase;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    bit_en   = 1'b0;
    repeat (3) tick();
    bit_en = 1'b0;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_bit", out_bit, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", frame_done, 0);
    checkOutput("rst_sync", out_sync, 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    monEn    = 1'b1;
    tick();
    checkOutput("post_rst_ready", in_ready, 1);
    checkOutput("post_rst_idle", out_valid, 0);

    $display("[TB] A5 with bit_en tied high");
    applyStimulus(8'hA5, 12'hBA5, 1'b0, 1, FRAME_L);
    checkOutput("first_valid", out_valid, 1);
    checkOutput("first_sync", out_sync, 1);
    repeat (FRAME_L) tick();
    checkOutput("done_at_T_L_1", frame_done, 1);

    $display("[TB] 3C with bit_en one cycle in three");
    applyStimulus(8'h3C, 12'hB3C, 1'b0, 3, FRAME_L);
    repeat (3 * FRAME_L) tick();
    checkOutput("slow_done", frame_done, 1);

    $display("[TB] second word held during a frame");
    applyStimulus(8'h81, 12'hB81, 1'b0, 1, FRAME_L);
    in_valid = 1'b1;
    in_data  = 8'h5E;
    for (int k = 1; k <= FRAME_L; k++) begin
      checkOutput("busy_not_ready", in_ready, 0);
      tick();
    end
    checkOutput("b2b_done", frame_done, 1);
    checkOutput("b2b_ready", in_ready, 1);
    pushFrame(12'hB5E, 1'b1, 1, FRAME_L);
    tick();
    in_valid = 1'b0;
    checkOutput("b2b_preamble_valid", out_valid, 1);
    checkOutput("b2b_preamble_sync", out_sync, 1);
    waitDone();

    $display("[TB] reset on the 6th bit");
    applyStimulus(8'hA5, 12'hBA5, 1'b0, 1, 6);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_bit", out_bit, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", frame_done, 0);
    checkOutput("abort_ready", in_ready, 0);
    reset = 1'b0;
    tick();
    checkOutput("abort_done_after", frame_done, 0);
    checkOutput("abort_ready_after", in_ready, 1);
    applyStimulus(8'h69, 12'hB69, 1'b0, 1, FRAME_L);
    waitDone();

    $display("[TB] parity patterns 07 and 03");
    applyStimulus(8'h07, 12'hB07, 1'b1, 1, FRAME_L);
    waitDone();
    applyStimulus(8'h03, 12'hB03, 1'b0, 1, FRAME_L);
    waitDone();

    $display("[TB] ten back-to-back zero frames");
    enPeriod = 1;
    bit_en   = 1'b1;
    loopMode = 1'b1;
    detBase  = detCnt;
    in_data  = 8'h00;
    in_valid = 1'b1;
    sent     = 0;
    guard    = 0;
    while (sent < 10 && guard < 1000) begin
      if (in_ready) begin
        pushFrame(12'hB00, 1'b0, 1, FRAME_L);
        sent++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    checkOutput("loop_sent", sent, 10);
    waitDone();
    loopMode = 1'b0;
    checkOutput("loop_detections", detCnt - detBase, 10);

    repeat (3) tick();
    checkOutput("queue_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
